// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: RV32 data memory with request/response handshake.
// Byte/half/word stores with lane enables, sign/zero-extended loads,
// registered read pipeline (READ_LAT 1 or 2), misalignment/range error
// reporting and a one-word-per-cycle clear walk after reset.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid/req_ready request handshake (req_ready is combinational)
//   req_we              1 = store, 0 = load
//   req_size            00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned        loads: 1 = zero-extend, 0 = sign-extend
//   req_addr            byte address
//   req_wdata           right-aligned store data
//   rsp_valid           one pulse per accepted request, READ_LAT cycles later
//   rsp_rdata           extended load data, 0 for stores and errors
//   rsp_err_misaligned  alignment / illegal-size error
//   rsp_err_range       address beyond DEPTH words
//   busy                clear walk in progress
module data_mem_ctrl #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned READ_LAT       = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err_misaligned,
  output logic        rsp_err_range,
  output logic        busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_clear_idx, w_clear_idx_nxt;
  logic                w_clr_we;
  logic [31:0]         r_mem [DEPTH];

  logic                w_accept;
  logic [ADDR_W-1:0]   w_idx;
  logic [1:0]          w_lane;
  logic                w_err_range, w_err_mis, w_err;
  logic [31:0]         w_rd_word, w_rd_shift, w_load;
  logic [3:0]          w_be;
  logic [31:0]         w_wlanes;

  logic                r_v1, r_em1, r_er1;
  logic [31:0]         r_d1;

  // State register; reset restarts the clear walk from word 0
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
      r_clear_idx <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_clear_idx <= w_clear_idx_nxt;
    end
  end

  // Next state: walk one word per cycle, then open for requests
  always_comb begin
    w_state_nxt     = r_state;
    w_clear_idx_nxt = r_clear_idx;
    w_clr_we        = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clr_we        = 1'b1;
        w_clear_idx_nxt = r_clear_idx + ADDR_W'(1);
        if (r_clear_idx == ADDR_W'(DEPTH - 1)) w_state_nxt = S_READY;
      end
      default: ;
    endcase
  end

  assign req_ready = (r_state == S_READY) && !reset;
  assign busy      = (r_state == S_CLEAR);
  assign w_accept  = req_valid && req_ready;

  assign w_idx       = req_addr[ADDR_W+1:2];
  assign w_lane      = req_addr[1:0];
  assign w_err_range = (req_addr >> (ADDR_W + 2)) != 32'd0;
  assign w_err_mis   = (req_size == 2'b11) ||
                       (req_size == 2'b01 && req_addr[0]) ||
                       (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign w_err       = w_err_range || w_err_mis;

  // Load path: pick the addressed lane, then extend
  assign w_rd_word  = r_mem[w_idx];
  assign w_rd_shift = w_rd_word >> {w_lane, 3'b000};

  always_comb begin
    w_load = w_rd_word;
    case (req_size)
      2'b00: w_load = req_unsigned ? {24'd0, w_rd_shift[7:0]}
                                   : {{24{w_rd_shift[7]}}, w_rd_shift[7:0]};
      2'b01: w_load = req_unsigned ? {16'd0, w_rd_shift[15:0]}
                                   : {{16{w_rd_shift[15]}}, w_rd_shift[15:0]};
      default: ;
    endcase
  end

  // Store path: replicate data across lanes, enable only the addressed ones
  always_comb begin
    w_be     = 4'b0000;
    w_wlanes = req_wdata;
    case (req_size)
      2'b00: begin
        w_be     = 4'b0001 << w_lane;
        w_wlanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be     = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{req_wdata[15:0]}};
      end
      2'b10: w_be = 4'b1111;
      default: ;
    endcase
  end

  // Memory array: clear walk or lane-enabled store
  always_ff @(posedge clk) begin
    if (w_clr_we && !reset) begin
      r_mem[r_clear_idx] <= 32'd0;
    end else if (w_accept && req_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
      end
    end
  end

  // First response stage, loaded at the accepting edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1  <= 1'b0;
      r_d1  <= 32'd0;
      r_em1 <= 1'b0;
      r_er1 <= 1'b0;
    end else begin
      r_v1  <= w_accept;
      r_d1  <= (w_accept && !req_we && !w_err) ? w_load : 32'd0;
      r_em1 <= w_accept && w_err_mis;
      r_er1 <= w_accept && w_err_range;
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic        r_v2, r_em2, r_er2;
      logic [31:0] r_d2;

      // Extra output register stage
      always_ff @(posedge clk) begin
        if (reset) begin
          r_v2  <= 1'b0;
          r_d2  <= 32'd0;
          r_em2 <= 1'b0;
          r_er2 <= 1'b0;
        end else begin
          r_v2  <= r_v1;
          r_d2  <= r_d1;
          r_em2 <= r_em1;
          r_er2 <= r_er1;
        end
      end

      assign rsp_valid          = r_v2;
      assign rsp_rdata          = r_d2;
      assign rsp_err_misaligned = r_em2;
      assign rsp_err_range      = r_er2;
    end else begin : g_lat1
      assign rsp_valid          = r_v1;
      assign rsp_rdata          = r_d1;
      assign rsp_err_misaligned = r_em1;
      assign rsp_err_range      = r_er1;
    end
  endgenerate

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: one READ_LAT=1 and one READ_LAT=2 instance
// share stimulus; a byte-array model predicts responses and readiness.
module tb_data_mem_ctrl;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned NB    = DEPTH * 4;

  typedef struct {
    int          due;
    logic [31:0] rd;
    logic        em;
    logic        er;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        ready1, ready2, v1, v2, em1, em2, er1, er2, busy1, busy2;
  logic [31:0] rd1, rd2;

  int          total = 0;
  int          bad   = 0;
  int          edge_cnt = 0;
  int          clr_cnt = 0;
  bit          known = 0;
  logic [7:0]  mmem [NB];
  rsp_t        q1[$];
  rsp_t        q2[$];

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_W(AW), .READ_LAT(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready1),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(v1),
    .rsp_rdata(rd1), .rsp_err_misaligned(em1), .rsp_err_range(er1),
    .busy(busy1));

  data_mem_ctrl #(.ADDR_W(AW), .READ_LAT(2), .CLEAR_ON_RESET(1)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready2),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(v2),
    .rsp_rdata(rd2), .rsp_err_misaligned(em2), .rsp_err_range(er2),
    .busy(busy2));

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h want=%08h (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  // Compare one instance's response outputs against its expected queue
  task automatic expect_rsp(input int lat, input logic v, input logic [31:0] rd,
                            input logic em, input logic er);
    rsp_t e;
    bit   has;
    has = 0;
    if (lat == 1) begin
      if (q1.size() > 0 && q1[0].due == edge_cnt) begin e = q1.pop_front(); has = 1; end
    end else begin
      if (q2.size() > 0 && q2[0].due == edge_cnt) begin e = q2.pop_front(); has = 1; end
    end
    check_val(lat == 1 ? "rsp_valid_l1" : "rsp_valid_l2", 32'(v), 32'(has));
    if (has) begin
      check_val(lat == 1 ? "rdata_l1" : "rdata_l2", rd, e.rd);
      check_val(lat == 1 ? "err_mis_l1" : "err_mis_l2", 32'(em), 32'(e.em));
      check_val(lat == 1 ? "err_rng_l1" : "err_rng_l2", 32'(er), 32'(e.er));
    end
  endtask

  // Reference behaviour of one accepted request on the byte array
  task automatic model_access(input logic we, input logic [1:0] sz, input logic u,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] rd, output logic em,
                              output logic er);
    int          nb;
    logic [31:0] val;
    er  = (a >= 32'(NB));
    em  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    rd  = 32'd0;
    val = 32'd0;
    if (!em && !er) begin
      nb = 1 << sz;
      if (we) begin
        for (int k = 0; k < nb; k++) mmem[int'(a) + k] = wd[8*k +: 8];
      end else begin
        for (int k = 0; k < nb; k++) val = val | (32'(mmem[int'(a) + k]) << (8 * k));
        if (nb == 1)      rd = u ? val : {{24{val[7]}}, val[7:0]};
        else if (nb == 2) rd = u ? val : {{16{val[15]}}, val[15:0]};
        else              rd = val;
      end
    end
  endtask

  // One clock cycle: drive, check ready/busy, predict, clock, check responses
  task automatic cycle(input logic rst, input logic v, input logic we,
                       input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    bit          rdy;
    logic [31:0] erd;
    logic        eem, eer;
    rsp_t        e;
    reset = rst; req_valid = v; req_we = we; req_size = sz;
    req_unsigned = u; req_addr = a; req_wdata = wd;
    #1;
    rdy = known && !rst && (clr_cnt >= int'(DEPTH));
    if (known) begin
      check_val("req_ready_l1", 32'(ready1), 32'(rdy));
      check_val("req_ready_l2", 32'(ready2), 32'(rdy));
      check_val("busy_l1", 32'(busy1), 32'(clr_cnt < int'(DEPTH)));
      check_val("busy_l2", 32'(busy2), 32'(clr_cnt < int'(DEPTH)));
    end
    if (v && rdy) begin
      model_access(we, sz, u, a, wd, erd, eem, eer);
      e.rd = erd; e.em = eem; e.er = eer;
      e.due = edge_cnt + 1; q1.push_back(e);
      e.due = edge_cnt + 2; q2.push_back(e);
    end
    @(posedge clk);
    edge_cnt++;
    #1;
    if (rst) begin
      known   = 1;
      clr_cnt = 0;
      q1.delete();
      q2.delete();
      for (int i = 0; i < int'(NB); i++) mmem[i] = 8'h00;
    end else if (known && clr_cnt < int'(DEPTH)) begin
      clr_cnt++;
    end
    if (known) begin
      expect_rsp(1, v1, rd1, em1, er1);
      expect_rsp(2, v2, rd2, em2, er2);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    cycle(1'b0, 1'b1, 1'b1, sz, 1'b0, a, wd);
  endtask

  task automatic ld(input logic [1:0] sz, input logic u, input logic [31:0] a);
    cycle(1'b0, 1'b1, 1'b0, sz, u, a, 32'd0);
  endtask

  task automatic rst_walk;
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    // Requests during the walk must be ignored
    for (int i = 0; i < int'(DEPTH); i++) ld(2'd2, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;

    rst_walk();
    for (int i = 0; i < int'(NB); i += 4) ld(2'd2, 1'b0, 32'(i));

    // Sub-word loads with extension
    st(2'd2, 32'h10, 32'h80FF7F01);
    ld(2'd0, 1'b0, 32'h10); ld(2'd0, 1'b0, 32'h11);
    ld(2'd0, 1'b0, 32'h12); ld(2'd0, 1'b0, 32'h13);
    ld(2'd0, 1'b1, 32'h13); ld(2'd1, 1'b0, 32'h12); ld(2'd1, 1'b1, 32'h12);

    // Sub-word stores merge into the word
    st(2'd2, 32'h20, 32'h0); st(2'd0, 32'h21, 32'hAB); st(2'd1, 32'h22, 32'h1234);
    ld(2'd2, 1'b0, 32'h20);
    idle(2);

    // Error cases leave memory untouched
    ld(2'd2, 1'b0, 32'h06); st(2'd1, 32'h03, 32'hFFFF); st(2'd3, 32'h00, 32'hFFFFFFFF);
    ld(2'd2, 1'b0, 32'h00); ld(2'd2, 1'b0, 32'h04);
    st(2'd2, 32'(NB), 32'hDEADBEEF); st(2'd2, 32'h8000_0000, 32'h1);
    ld(2'd2, 1'b0, 32'h00);

    // Back-to-back store then load to the same word
    st(2'd2, 32'h08, 32'hCAFEF00D); ld(2'd2, 1'b0, 32'h08);
    idle(3);

    // Reset mid-walk restarts the full walk
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    idle(5);
    rst_walk();

    // Reset with a load in flight drops the late response
    st(2'd2, 32'h08, 32'h5A5A5A5A);
    ld(2'd2, 1'b0, 32'h08);
    rst_walk();
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      a  = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, int'(NB) - 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if (sz == 2'd1 && $urandom_range(0, 3) != 0) a[0] = 1'b0;
      if (sz == 2'd2 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
            1'($urandom), sz, 1'($urandom), a, $urandom);
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised RV32 data memory with a request/response handshake, replacing the fixed 256-word, word-only, combinational-read data memory.
- Adds byte/half/word stores with byte lanes.
- Adds sign- and zero-extended loads.
- Adds a registered read pipeline with configurable latency.
- Adds misalignment and range error reporting.
- Adds a synthesizable sequential clear-on-reset: one word per cycle, instead of a one-cycle array clear.

Sits between the core's MEM stage (or the FFT load/store path) and on-chip RAM.

Parameters:
- ADDR_W, 8, word-index width; DEPTH = 2**ADDR_W words.
- READ_LAT, 1, request-to-response latency in cycles; legal values 1 or 2 (2 adds an output register).
- CLEAR_ON_RESET, 1, 1 = zero all words after reset via the clear walk; 0 = contents retained, ready immediately.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block accepts a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  one-cycle pulse per accepted request
- rsp_rdata  out  32  load result, extended; 0 for stores and errors
- rsp_err_misaligned  out  1  valid with rsp_valid
- rsp_err_range  out  1  valid with rsp_valid
- busy  out  1  clear walk in progress

Behaviour:
- Reset (clk = clk, reset = reset, synchronous, active-high):
  - rsp_valid=0, rsp_rdata=0, both error flags 0, pipeline flushed.
  - CLEAR_ON_RESET=1: state=CLEAR, clear_idx=0, busy=1.
  - CLEAR_ON_RESET=0: state=READY, busy=0.
- States: CLEAR, READY. req_ready = (state==READY) && !reset.
- CLEAR:
  - Writes 0 to mem[clear_idx] each cycle, then increments clear_idx.
  - At clear_idx==DEPTH-1, after that write, next state is READY and busy drops.
  - Takes exactly DEPTH cycles after reset deasserts.
  - Reset asserted mid-walk restarts the walk at clear_idx=0.
  - Requests are ignored, not queued.
- Accept condition: req_valid && req_ready. At most one request per cycle; fully pipelined, with a new request acceptable every cycle.
- Word index = req_addr[ADDR_W+1:2]; lane = req_addr[1:0].
- Range error: req_addr[31:ADDR_W+2] != 0.
- Misaligned error, any of:
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - size 11.
- Both error flags may be set together.
- Any error: memory unchanged, rsp_rdata=0, response still issued.
- Store byte enables:
  - byte: lane bit only, data req_wdata[7:0] on that lane.
  - half: lanes {addr[1],0} and {addr[1],1}, data req_wdata[15:0].
  - word: all 4 lanes.
  - Write commits at the accepting edge.
- Load:
  - Reads the word at the accepting edge.
  - Extracts the selected byte/half, extends per req_unsigned.
  - Word loads ignore req_unsigned.
- Response timing:
  - READ_LAT=1: rsp_valid, data and flags registered at the accepting edge, visible the next cycle.
  - READ_LAT=2: one further register stage.
  - Stores and errored requests respond with the same latency as loads, so responses stay in order.
- Hazards:
  - A load accepted the cycle after a store to the same word returns the new data.
  - No same-cycle read/write conflict exists, since there is a single request port.
- Reset during in-flight requests drops them: no rsp_valid is issued for them.

Test Plan:
- CLEAR_ON_RESET=1, ADDR_W=4: pulse reset for 1 cycle -> busy=1 and req_ready=0 for exactly 16 cycles; then word loads of 0x00..0x3C all return 0x00000000.
- sw 0x80FF7F01 @0x10, then lb @0x10/0x11/0x12/0x13 -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; lbu @0x13 -> 0x00000080; lh @0x12 -> 0xFFFF80FF; lhu @0x12 -> 0x000080FF.
- sw 0x00000000 @0x20, then sb 0xAB @0x21, then sh 0x1234 @0x22, then lw @0x20 -> 0x1234AB00.
- lw @0x06, sh @0x03, size=11 @0x00 -> each responds err_misaligned=1, rdata=0; a following lw shows memory unchanged. sw @(DEPTH*4) -> err_range=1, no write.
- READ_LAT=1 and 2: back-to-back sw @0x8 then lw @0x8 on consecutive cycles -> rsp_valid pulses 1 and 2 (resp. 2 and 3) cycles after each accept, in order; the load returns the stored value.
- Assert reset at clear_idx=5 -> walk restarts at 0; busy stays high for a full DEPTH cycles after release. Reset while a load is in flight -> no rsp_valid afterwards.
